alu_cmd_sequencer: RTL and testbench

//  Initiator side of the ALU_16bit operand/function interface. Accepts ALU

---
 rtl/alu_cmd_sequencer.sv | 105 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues them one at a time, and returns checked results
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int FUN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [FUN_W-1:0] cmd_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FUN_W-1:0] alu_fun,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      ops_done,
  output logic [7:0]       err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LAT + 2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [FUN_W-1:0] mem_f [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic push, pop;
  logic [3:0] flags, exp_flags;
  assign cmd_ready = count != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign busy = state != IDLE || count != '0;
  assign flags = {arith_flag, logic_flag, cmp_flag, shift_flag};
  // Flag class the ALU must report for the function currently issued
  assign exp_flags = 32'(alu_fun) <= 3  ? 4'b1000 :
                     32'(alu_fun) <= 9  ? 4'b0100 :
                     32'(alu_fun) <= 12 ? 4'b0010 :
                     32'(alu_fun) <= 14 ? 4'b0001 : 4'b0000;
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr] <= cmd_a;
      mem_b[wr_ptr] <= cmd_b;
      mem_f[wr_ptr] <= cmd_fun;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          alu_a   <= mem_a[rd_ptr];
          alu_b   <= mem_b[rd_ptr];
          alu_fun <= mem_f[rd_ptr];
          cnt     <= CW'(ALU_LAT);
          state   <= WAIT;
        end
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rsp_data  <= alu_out;
          rsp_flags <= flags;
          rsp_err   <= flags != exp_flags;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ops_done  <= ops_done + 1'b1;
          err_count <= err_count + 8'(rsp_err && err_count != 8'hFF);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: vector table, directed corner cases and a randomized scoreboard
module tb_alu_cmd_sequencer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, rsp_ready = 0, xv = 0;
  logic [15:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] cmd_fun = 0, flag_xor = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [15:0] alu_a, alu_b, m_out, rsp_data, ops_done;
  logic [3:0] alu_fun, m_fl, rsp_flags;
  logic [7:0] err_count;
  logic x_rv [2];
  logic [15:0] x_rd [2];
  logic [3:0] x_rf [2];
  logic x_re [2];
  int n_pass = 0, n_tot = 0;

  function automatic logic [15:0] alu_f(input logic [15:0] a, b, input logic [3:0] f);
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 0) ? 16'd0 : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a & b);
      4'd7:  return ~(a | b);
      4'd8:  return a ^ b;
      4'd9:  return ~(a ^ b);
      4'd10: return {15'd0, a == b};
      4'd11: return {15'd0, a > b};
      4'd12: return {15'd0, a < b};
      4'd13: return a >> 1;
      4'd14: return a << 1;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_cls(input logic [3:0] f);
    if (f <= 3) return 4'b1000;
    if (f <= 9) return 4'b0100;
    if (f <= 12) return 4'b0010;
    if (f <= 14) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_tot++;
    $display("FAIL %s: bound expired", name);
  endtask

  // single-cycle ALU stub; flag_xor lets a test corrupt the reported flags
  always @(posedge clk) begin
    m_out <= alu_f(alu_a, alu_b, alu_fun);
    m_fl  <= exp_cls(alu_fun) ^ flag_xor;
  end

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(m_out),
    .arith_flag(m_fl[3]), .logic_flag(m_fl[2]), .cmp_flag(m_fl[1]), .shift_flag(m_fl[0]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done), .err_count(err_count)
  );

  for (genvar g = 0; g < 2; g++) begin : gx
    logic [15:0] aa, ab, ro, r1, r2, od;
    logic [3:0] af, rf, f1, f2;
    logic cr, bz;
    logic [7:0] ec;
    always @(posedge clk) begin
      r1 <= alu_f(aa, ab, af);
      f1 <= exp_cls(af);
      r2 <= r1;
      f2 <= f1;
    end
    assign ro = (g == 0) ? alu_f(aa, ab, af) : r2;
    assign rf = (g == 0) ? exp_cls(af) : f2;
    alu_cmd_sequencer #(.ALU_LAT(2 * g)) u (
      .clk(clk), .rst(rst), .cmd_valid(xv), .cmd_ready(cr),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .alu_a(aa), .alu_b(ab), .alu_fun(af), .alu_out(ro),
      .arith_flag(rf[3]), .logic_flag(rf[2]), .cmp_flag(rf[1]), .shift_flag(rf[0]),
      .rsp_valid(x_rv[g]), .rsp_ready(1'b1), .rsp_data(x_rd[g]), .rsp_flags(x_rf[g]),
      .rsp_err(x_re[g]), .busy(bz), .ops_done(od), .err_count(ec)
    );
  end

  // reference model: commands in acceptance order, responses must match them in order
  typedef struct {logic [15:0] a, b; logic [3:0] f;} cmd_t;
  cmd_t q[$];
  int unsigned ops_m = 0, errc_m = 0;
  initial forever begin
    cmd_t c;
    @(negedge clk);
    if (rst) begin
      q.delete();
      ops_m = 0;
      errc_m = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) fail("sb_unexpected_rsp");
        else begin
          c = q.pop_front();
          check("sb_data", rsp_data, alu_f(c.a, c.b, c.f));
          check("sb_flags", rsp_flags, exp_cls(c.f) ^ flag_xor);
          check("sb_err", rsp_err, flag_xor != 0);
          ops_m = (ops_m + 1) % 65536;
          if (flag_xor != 0 && errc_m < 255) errc_m++;
        end
      end
      if (cmd_valid && cmd_ready) q.push_back('{cmd_a, cmd_b, cmd_fun});
    end
  end

  task automatic push(input logic [15:0] a, b, input logic [3:0] f);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_a = a; cmd_b = b; cmd_fun = f; cmd_valid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) fail("push_timeout");
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin k = i; break; end
    end
    if (k == 0) fail("rsp_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) fail("idle_timeout");
    @(posedge clk); #1;
  endtask

  typedef struct {logic [3:0] f; logic [15:0] a, b, d; logic [3:0] fl;} vec_t;
  vec_t tv[12];

  initial begin
    int k;
    int kx [2];
    tv[0]  = '{4'd0,  16'd20,     16'd30,     16'd50,     4'b1000};
    tv[1]  = '{4'd1,  16'd100,    16'd30,     16'd70,     4'b1000};
    tv[2]  = '{4'd2,  16'd300,    16'd3,      16'd900,    4'b1000};
    tv[3]  = '{4'd7,  16'd50,     16'd100,    16'd65417,  4'b0100};
    tv[4]  = '{4'd4,  16'h00F0,   16'h0FF0,   16'h00F0,   4'b0100};
    tv[5]  = '{4'd8,  16'hFFFF,   16'h0F0F,   16'hF0F0,   4'b0100};
    tv[6]  = '{4'd10, 16'd5,      16'd5,      16'd1,      4'b0010};
    tv[7]  = '{4'd12, 16'd5,      16'd9,      16'd1,      4'b0010};
    tv[8]  = '{4'd13, 16'h8000,   16'd0,      16'h4000,   4'b0001};
    tv[9]  = '{4'd14, 16'd100,    16'd0,      16'd200,    4'b0001};
    tv[10] = '{4'd15, 16'd1,      16'd2,      16'd0,      4'b0000};
    tv[11] = '{4'd3,  16'd100,    16'd7,      16'd14,     4'b1000};
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu", {alu_a, alu_b, alu_fun}, 0);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_flags, rsp_err}, 0);
    check("rst_stats", {busy, ops_done, err_count}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    rsp_ready = 1;
    foreach (tv[i]) begin
      push(tv[i].a, tv[i].b, tv[i].f);
      wait_valid(k);
      check("vec_latency", k, 4);
      check("vec_data", rsp_data, tv[i].d);
      check("vec_flags", rsp_flags, tv[i].fl);
      check("vec_err", rsp_err, 0);
      wait_idle();
      check("vec_hold_operands", {alu_a, alu_b, alu_fun}, {tv[i].a, tv[i].b, tv[i].f});
    end
    check("vec_ops_done", ops_done, 12);
    rsp_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1; cmd_a = 16'(i * 3 + 1); cmd_b = 16'(i + 2); cmd_fun = 4'(i * 2);
      @(negedge clk);
      check("full_cmd_ready", cmd_ready, i < 5);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    check("full_accepted", q.size(), 5);
    check("full_busy", busy, 1);
    rsp_ready = 1;
    wait_idle();
    check("full_drain_ops", ops_done, 17);
    check("full_drain_empty", q.size(), 0);
    rsp_ready = 0;
    push(16'd50, 16'd100, 4'd7);
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, 16'd65417);
      check("hold_flags", rsp_flags, 4'b0100);
      @(negedge clk);
    end
    check("hold_ops_before", ops_done, 17);
    @(posedge clk); #1;
    rsp_ready = 1;
    repeat (3) @(negedge clk);
    check("hold_ops_after", ops_done, 18);
    check("hold_valid_drop", rsp_valid, 0);
    wait_idle();
    repeat (400) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_a = 16'($urandom);
      cmd_b = 16'($urandom);
      cmd_fun = 4'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    rsp_ready = 1;
    wait_idle();
    check("rand_ops", ops_done, ops_m);
    check("rand_err_count", err_count, 0);
    check("rand_empty", q.size(), 0);
    flag_xor = 4'b0010;
    push(16'd1, 16'd2, 4'd0);
    wait_idle();
    check("err_one", err_count, 1);
    repeat (300) push(16'($urandom), 16'($urandom), 4'd0);
    wait_idle();
    check("err_saturate", err_count, 255);
    check("err_model", err_count, errc_m);
    check("err_ops", ops_done, ops_m);
    flag_xor = 0;
    push(16'd9, 16'd4, 4'd1);
    @(posedge clk); #2;
    check("wait_busy", busy, 1);
    check("wait_issued", {alu_a, alu_b, alu_fun}, {16'd9, 16'd4, 4'd1});
    rst = 1;
    #1;
    check("async_alu", {alu_a, alu_b, alu_fun}, 0);
    check("async_rsp", {rsp_valid, rsp_data, rsp_flags, rsp_err}, 0);
    check("async_stats", {busy, ops_done, err_count}, 0);
    check("async_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    push(16'd7, 16'd6, 4'd2);
    wait_idle();
    check("post_rst_ops", ops_done, 1);
    check("post_rst_data", rsp_data, 42);
    check("post_rst_err_count", err_count, 0);
    cmd_a = 16'd100; cmd_b = 16'd0; cmd_fun = 4'd14; xv = 1;
    @(posedge clk); #1;
    xv = 0;
    kx[0] = 0;
    kx[1] = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (x_rv[g] && kx[g] == 0) begin
          kx[g] = i;
          check("lat_var_data", x_rd[g], 200);
          check("lat_var_flags", x_rf[g], 4'b0001);
          check("lat_var_err", x_re[g], 0);
        end
    end
    check("lat0_latency", kx[0], 3);
    check("lat2_latency", kx[1], 5);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
